// File: rtl/dm_mem_responder.sv
// Data-memory responder: word RAM behind a strobe/address checker.
// Accesses complete after WAIT_CYCLES wait states with a one-cycle ack.
module dm_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  wea_mem,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    localparam int         DEPTH   = 1 << ADDR_WIDTH;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;
    logic [3:0]  strb_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] idx;
    logic                  strb_ok;
    logic                  range_ok;
    logic                  legal;
    logic                  do_write;

    assign idx = addr_q[ADDR_WIDTH+1:2];

    // Strobe must be one of the legal lane patterns and match the byte offset.
    always_comb begin
        strb_ok = 1'b0;
        case (strb_q)
            4'b0000, 4'b1111: strb_ok = 1'b1;
            4'b0011: strb_ok = ~addr_q[1];
            4'b1100: strb_ok = addr_q[1];
            4'b0001: strb_ok = (addr_q[1:0] == 2'b00);
            4'b0010: strb_ok = (addr_q[1:0] == 2'b01);
            4'b0100: strb_ok = (addr_q[1:0] == 2'b10);
            4'b1000: strb_ok = (addr_q[1:0] == 2'b11);
            default: strb_ok = 1'b0;
        endcase
    end

    assign range_ok = (addr_q[31:ADDR_WIDTH+2] == '0);
    assign legal    = strb_ok & range_ok;
    assign do_write = rstn & (state == ACCESS) & legal & (|strb_q);

    // Byte-lane RAM write; contents survive reset, reset only blocks the write.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (strb_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Control FSM: capture request, count wait states, check and respond.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
            rdata   <= 32'd0;
            addr_q  <= 32'd0;
            strb_q  <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= req;
                    if (req) begin
                        addr_q  <= addr;
                        strb_q  <= wea_mem;
                        wdata_q <= wdata;
                        cnt     <= WAIT_LD;
                        state   <= (WAIT_CYCLES == 0) ? ACCESS : WAIT;
                    end
                end
                WAIT: begin
                    busy <= 1'b1;
                    cnt  <= cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    busy  <= 1'b1;
                    ack   <= 1'b1;
                    state <= IDLE;
                    if (!legal) begin
                        fault <= 1'b1;
                        rdata <= 32'd0;
                    end else begin
                        fault <= 1'b0;
                        if (strb_q == 4'b0000) begin
                            rdata <= mem[idx];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_mem_responder.sv
// Directed bench for dm_mem_responder: latency, lanes, faults,
// busy drop, reset abort and zero-wait operation.
module tb_dm_mem_responder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  wea_mem;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        fault;

    logic        req0;
    logic [31:0] addr0;
    logic [3:0]  wea0;
    logic [31:0] wdata0;
    logic [31:0] rdata0;
    logic        ack0;
    logic        busy0;
    logic        fault0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dm_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .req(req), .addr(addr),
        .wea_mem(wea_mem), .wdata(wdata), .rdata(rdata),
        .ack(ack), .busy(busy), .fault(fault)
    );

    dm_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rstn(rstn), .req(req0), .addr(addr0),
        .wea_mem(wea0), .wdata(wdata0), .rdata(rdata0),
        .ack(ack0), .busy(busy0), .fault(fault0)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, return cycles from capture edge to ack
    // (sampled at negedges); returns at the negedge of the ack cycle.
    task automatic access(input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int lat);
        @(negedge clk);
        addr = a; wea_mem = s; wdata = d; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (!ack && lat < 20) begin
            lat++;
            @(negedge clk);
        end
    endtask

    int lat;
    int n_ack;
    int a_first;
    int a_second;

    initial begin
        rstn = 1'b0; req = 1'b0; addr = '0; wea_mem = '0; wdata = '0;
        req0 = 1'b0; addr0 = '0; wea0 = '0; wdata0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rstn = 1'b1;

        // Full-word write then read
        access(32'h10, 4'b1111, 32'hDEADBEEF, lat);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_fault", 32'(fault), 32'd0);
        chk("wr_busy", 32'(busy), 32'd1);
        access(32'h10, 4'b0000, 32'h0, lat);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_data", rdata, 32'hDEADBEEF);
        chk("rd_fault", 32'(fault), 32'd0);
        @(negedge clk);
        chk("ack_pulse", 32'(ack), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("rdata_hold", rdata, 32'hDEADBEEF);

        // Byte and halfword lanes
        access(32'h20, 4'b1111, 32'h11223344, lat);
        access(32'h22, 4'b0100, 32'hAAAAAAAA, lat);
        chk("byte_wr_rdata_hold", rdata, 32'hDEADBEEF);
        access(32'h20, 4'b0000, 32'h0, lat);
        chk("byte_lane2", rdata, 32'h11AA3344);
        access(32'h22, 4'b1100, 32'h55665566, lat);
        access(32'h20, 4'b0000, 32'h0, lat);
        chk("half_upper", rdata, 32'h55663344);

        // Faults
        access(32'h22, 4'b0011, 32'hFFFFFFFF, lat);
        chk("f_half_lat", 32'(lat), 32'd3);
        chk("f_half_fault", 32'(fault), 32'd1);
        chk("f_half_rdata", rdata, 32'd0);
        @(negedge clk);
        chk("f_hold", 32'(fault), 32'd1);
        access(32'h20, 4'b0101, 32'hFFFFFFFF, lat);
        chk("f_strb_fault", 32'(fault), 32'd1);
        access(32'h0000_1000, 4'b0000, 32'h0, lat);
        chk("f_range_fault", 32'(fault), 32'd1);
        chk("f_range_rdata", rdata, 32'd0);
        access(32'h0000_1020, 4'b1111, 32'hFFFFFFFF, lat);
        chk("f_range_wr_fault", 32'(fault), 32'd1);
        access(32'h20, 4'b0000, 32'h0, lat);
        chk("f_ram_unchanged", rdata, 32'h55663344);
        chk("f_cleared", 32'(fault), 32'd0);

        // Busy drop: req held for six sampling edges
        @(negedge clk);
        addr = 32'h10; wea_mem = 4'b0000; req = 1'b1;
        n_ack = 0; a_first = -1; a_second = -1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) req = 1'b0;
            if (k == 0) chk("drop_busy", 32'(busy), 32'd1);
            if (ack) begin
                if (n_ack == 0) a_first = k;
                else if (n_ack == 1) a_second = k;
                n_ack++;
            end
        end
        chk("drop_count", 32'(n_ack), 32'd2);
        chk("drop_first", 32'(a_first), 32'd3);
        chk("drop_second", 32'(a_second), 32'd7);

        // Reset during WAIT discards the pending write
        access(32'h30, 4'b1111, 32'h0, lat);
        @(negedge clk);
        addr = 32'h30; wea_mem = 4'b1111; wdata = 32'hCAFEF00D; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        n_ack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        chk("abort_no_ack", 32'(n_ack), 32'd0);
        access(32'h30, 4'b0000, 32'h0, lat);
        chk("abort_readback", rdata, 32'd0);

        // Zero wait states: write then read, req held across
        @(negedge clk);
        addr0 = 32'h10; wea0 = 4'b1111; wdata0 = 32'h12345678; req0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("w0_ack_n", 32'(ack0), 32'd0);
        chk("w0_busy_n", 32'(busy0), 32'd1);
        addr0 = 32'h10; wea0 = 4'b0000; wdata0 = 32'h0;
        @(posedge clk);
        @(negedge clk);
        chk("w0_ack_n1", 32'(ack0), 32'd1);
        chk("w0_fault", 32'(fault0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0;
        chk("w0_ack_n2", 32'(ack0), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("w0_ack_n3", 32'(ack0), 32'd1);
        chk("w0_rdata", rdata0, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        chk("w0_ack_n4", 32'(ack0), 32'd0);
        chk("w0_busy_n4", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
